// File: rtl/sha_sched_ctrl.sv
// sha_sched_ctrl: SHA-256 message schedule controller; streams W[0..63] using one shared external sigma unit.
// Build macro SHA_SCHED_STALL_CNT_EN adds a saturating stall_cnt output counting consumer stalls.
module sha_sched_ctrl #(
    parameter int DATA_W    = 32,
    parameter int SIGMA_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] m_in,
    input  logic              m_valid,
    output logic              m_ready,
    output logic [DATA_W-1:0] w_out,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [5:0]        w_idx,
    output logic [DATA_W-1:0] sig_in,
    output logic [31:0]       sig_k0,
    output logic [31:0]       sig_k1,
    output logic [31:0]       sig_k2,
    output logic              sig_run,
    input  logic [DATA_W-1:0] sig_out,
    output logic              busy,
    output logic              done
`ifdef SHA_SCHED_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, LOAD, EMIT, S0, S1, OUT, DONE} state_t;
    state_t            state, nxt;
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] s0, s1;
    logic [5:0]        t;
    logic [3:0]        cnt, ti;
    logic [2:0]        wcnt;
    logic              lat_hit;
    assign ti      = t[3:0];
    assign lat_hit = wcnt == 3'(SIGMA_LAT);
    assign busy    = state != IDLE;
    assign w_out   = w_valid ? mem[ti] : '0;
    assign w_idx   = w_valid ? t : 6'd0;
    // State register.
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nxt;
    // Next state and handshake/sigma-issue outputs; sigma operand and constants hold for the whole wait.
    always_comb begin
        nxt     = state;
        m_ready = 1'b0;
        w_valid = 1'b0;
        sig_run = 1'b0;
        sig_in  = '0;
        sig_k0  = 32'd0;
        sig_k1  = 32'd0;
        sig_k2  = 32'd0;
        done    = 1'b0;
        case (state)
            IDLE: nxt = start ? LOAD : IDLE;
            LOAD: begin
                m_ready = 1'b1;
                if (m_valid && cnt == 4'd15) nxt = EMIT;
            end
            EMIT: begin
                w_valid = 1'b1;
                if (w_ready) nxt = (t == 6'd63) ? DONE : (t >= 6'd15) ? S0 : EMIT;
            end
            S0: begin
                sig_in  = mem[ti + 4'd1];
                sig_k0  = 32'd7;
                sig_k1  = 32'd18;
                sig_k2  = 32'd3;
                sig_run = wcnt == 3'd0;
                if (lat_hit) nxt = S1;
            end
            S1: begin
                sig_in  = mem[ti - 4'd2];
                sig_k0  = 32'd17;
                sig_k1  = 32'd19;
                sig_k2  = 32'd10;
                sig_run = wcnt == 3'd0;
                if (lat_hit) nxt = OUT;
            end
            OUT: nxt = EMIT;
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    // Datapath: load counter, word index, sigma wait timer, sigma latches and the circular word buffer.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            t    <= '0;
            cnt  <= '0;
            wcnt <= '0;
            s0   <= '0;
            s1   <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    t   <= '0;
                    cnt <= '0;
                end
                LOAD: if (m_valid) begin
                    mem[cnt] <= m_in;
                    cnt      <= cnt + 4'd1;
                end
                EMIT: if (w_ready && t != 6'd63) t <= t + 6'd1;
                S0: begin
                    wcnt <= lat_hit ? 3'd0 : wcnt + 3'd1;
                    if (lat_hit) s0 <= sig_out;
                end
                S1: begin
                    wcnt <= lat_hit ? 3'd0 : wcnt + 3'd1;
                    if (lat_hit) s1 <= sig_out;
                end
                OUT: mem[ti] <= s1 + mem[ti - 4'd7] + s0 + mem[ti];
                default: ;
            endcase
        end
`ifdef SHA_SCHED_STALL_CNT_EN
    // Saturating count of cycles where a presented word is held off by the consumer.
    always_ff @(posedge clk or negedge rst)
        if (!rst) stall_cnt <= '0;
        else if (state == IDLE && start) stall_cnt <= '0;
        else if (w_valid && !w_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_sha_sched_ctrl.sv
// tb_sha_sched_ctrl: randomized check of sha_sched_ctrl at SIGMA_LAT 0, 1 and 3 against a SHA-256 schedule model.
`timescale 1ns/1ps
module tb_sha_sched_ctrl;
    localparam int NI = 3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, m_valid = 1'b0, w_ready = 1'b0;
    logic [31:0] m_in = 32'd0;
    always #5 clk = ~clk;

    logic        m_ready_v [NI];
    logic        w_valid_v [NI];
    logic        sig_run_v [NI];
    logic        busy_v    [NI];
    logic        done_v    [NI];
    logic [31:0] w_out_v   [NI];
    logic [31:0] sig_in_v  [NI];
    logic [31:0] k0_v      [NI];
    logic [31:0] k1_v      [NI];
    logic [31:0] k2_v      [NI];
    logic [31:0] sig_out_v [NI];
    logic [5:0]  w_idx_v   [NI];
`ifdef SHA_SCHED_STALL_CNT_EN
    logic [31:0] stall_v   [NI];
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] sig_f(input logic [31:0] x, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return rotr(x, int'(a[4:0])) ^ rotr(x, int'(b[4:0])) ^ (x >> c[4:0]);
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 3;
    endfunction

    // Behavioural sigma units: result shows up SIGMA_LAT cycles after the issue cycle, junk otherwise.
    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [31:0] pend;
        int          cd;
        always @(posedge clk or negedge rst)
            if (!rst) begin
                pend <= 32'd0;
                cd   <= 0;
            end else if (sig_run_v[g]) begin
                pend <= sig_f(sig_in_v[g], k0_v[g], k1_v[g], k2_v[g]);
                cd   <= L;
            end else if (cd > 0) cd <= cd - 1;
        assign sig_out_v[g] = (L == 0) ? (sig_run_v[g] ? sig_f(sig_in_v[g], k0_v[g], k1_v[g], k2_v[g]) : 32'hA5C3_5A3C)
                                       : ((cd == 1) ? pend : 32'hA5C3_5A3C);
        sha_sched_ctrl #(.DATA_W(32), .SIGMA_LAT(L)) dut (
            .clk(clk), .rst(rst), .start(start), .m_in(m_in), .m_valid(m_valid), .m_ready(m_ready_v[g]),
            .w_out(w_out_v[g]), .w_valid(w_valid_v[g]), .w_ready(w_ready), .w_idx(w_idx_v[g]),
            .sig_in(sig_in_v[g]), .sig_k0(k0_v[g]), .sig_k1(k1_v[g]), .sig_k2(k2_v[g]), .sig_run(sig_run_v[g]),
            .sig_out(sig_out_v[g]), .busy(busy_v[g]), .done(done_v[g])
`ifdef SHA_SCHED_STALL_CNT_EN
            , .stall_cnt(stall_v[g])
`endif
        );
    end

    logic [31:0] blk  [16];
    logic [31:0] gold [64];
    bit          is_abc = 1'b0;
    int          nvec = 0, nerr = 0;
    int          ld [NI], idx [NI], gap [NI], phase [NI], runs [NI], stalls [NI], blocks_done [NI];
    logic        active [NI], done_pend [NI], held [NI];
    logic [31:0] last_out [NI];

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s inst%0d (lat %0d) at %0t: got %h, expected %h", nm, i, lat_of(i), $time, got, want);
        end
    endtask

    // Single compare process: per instance, a transaction-level model of the block lifecycle.
    always @(negedge clk) begin
        logic was, ewv, acc;
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                chk("reset_outputs", i, 64'({m_ready_v[i], w_valid_v[i], sig_run_v[i], busy_v[i], done_v[i], w_idx_v[i],
                    w_out_v[i] | sig_in_v[i] | k0_v[i] | k1_v[i] | k2_v[i]
`ifdef SHA_SCHED_STALL_CNT_EN
                    | stall_v[i]
`endif
                    }), 64'd0);
                active[i] = 1'b0; done_pend[i] = 1'b0; held[i] = 1'b0;
                ld[i] = 0; idx[i] = 0; gap[i] = 0; phase[i] = 0; runs[i] = 0; stalls[i] = 0;
            end else begin
                was = active[i];
                ewv = active[i] && ld[i] == 16 && idx[i] < 64 && gap[i] >= ((idx[i] < 16) ? 0 : 2 * lat_of(i) + 3);
                acc = ewv && w_ready;
                chk("busy", i, 64'(busy_v[i]), 64'(active[i]));
                chk("m_ready", i, 64'(m_ready_v[i]), 64'(active[i] && ld[i] < 16));
                chk("w_valid", i, 64'(w_valid_v[i]), 64'(ewv));
                chk("done", i, 64'(done_v[i]), 64'(done_pend[i]));
                if (w_valid_v[i] && ewv) begin
                    chk("w_idx", i, 64'(w_idx_v[i]), 64'(idx[i]));
                    chk("w_out", i, 64'(w_out_v[i]), 64'(gold[idx[i]]));
                    if (held[i]) chk("w_out_stable", i, 64'(w_out_v[i]), 64'(last_out[i]));
                    if (is_abc && idx[i] == 16) chk("abc_w16", i, 64'(w_out_v[i]), 64'h6162_6380);
                    if (is_abc && idx[i] == 17) chk("abc_w17", i, 64'(w_out_v[i]), 64'h000F_0000);
                end
                if (sig_run_v[i]) begin
                    chk("sig_run_window", i, 64'(active[i] && ld[i] == 16 && idx[i] >= 16 && idx[i] < 64 && !ewv), 64'd1);
                    chk("sig_k0", i, 64'(k0_v[i]), (phase[i] != 0) ? 64'd17 : 64'd7);
                    chk("sig_k1", i, 64'(k1_v[i]), (phase[i] != 0) ? 64'd19 : 64'd18);
                    chk("sig_k2", i, 64'(k2_v[i]), (phase[i] != 0) ? 64'd10 : 64'd3);
                    chk("sig_in", i, 64'(sig_in_v[i]), 64'((phase[i] != 0) ? gold[(idx[i] - 2) & 63] : gold[(idx[i] - 15) & 63]));
                    runs[i]++;
                    phase[i] ^= 1;
                end
                if (done_pend[i]) begin
                    chk("sig_runs_per_block", i, 64'(runs[i]), 64'd96);
`ifdef SHA_SCHED_STALL_CNT_EN
                    chk("stall_cnt", i, 64'(stall_v[i]), 64'(stalls[i]));
`endif
                    blocks_done[i]++;
                    active[i] = 1'b0;
                    done_pend[i] = 1'b0;
                end
                if (!was && start) begin
                    active[i] = 1'b1; held[i] = 1'b0;
                    ld[i] = 0; idx[i] = 0; gap[i] = 0; phase[i] = 0; runs[i] = 0; stalls[i] = 0;
                end else if (was) begin
                    if (ld[i] < 16) begin
                        if (m_valid) ld[i]++;
                        gap[i] = 0;
                    end else if (acc) begin
                        if (idx[i] == 63) done_pend[i] = 1'b1;
                        idx[i]++;
                        gap[i] = 0;
                        held[i] = 1'b0;
                    end else begin
                        gap[i]++;
                        if (ewv) begin
                            stalls[i]++;
                            held[i] = 1'b1;
                            last_out[i] = w_out_v[i];
                        end
                    end
                end
            end
        end
    end

    task automatic make_gold();
        for (int t = 0; t < 16; t++) gold[t] = blk[t];
        for (int t = 16; t < 64; t++) gold[t] = ss1(gold[t-2]) + gold[t-7] + ss0(gold[t-15]) + gold[t-16];
    endtask

    task automatic set_abc();
        for (int k = 0; k < 16; k++) blk[k] = 32'd0;
        blk[0]  = 32'h6162_6380;
        blk[15] = 32'h0000_0018;
        is_abc  = 1'b1;
    endtask

    task automatic begin_block(input bit rm);
        int   k = 0, n = 0;
        logic a;
        make_gold();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (k < 16) begin
            m_valid = ($urandom % 4) != 0;
            m_in    = m_valid ? blk[k] : $urandom;
            start   = rm && ($urandom % 6 == 0);
            @(negedge clk) a = m_valid && m_ready_v[0];
            @(posedge clk); #1;
            if (a) k++;
            n++;
            if (n > 400) begin
                $display("FAIL load_timeout: %0d words accepted, 16 required", k);
                $fatal(1, "load did not complete");
            end
        end
        m_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic finish_block(input bit rm);
        int b [NI];
        int n = 0;
        for (int i = 0; i < NI; i++) b[i] = blocks_done[i];
        while (blocks_done[0] == b[0] || blocks_done[1] == b[1] || blocks_done[2] == b[2]) begin
            w_ready = rm ? 1'($urandom % 2) : 1'b1;
            start   = rm && busy_v[0] && busy_v[1] && busy_v[2] && ($urandom % 16 == 0);
            @(posedge clk); #1;
            n++;
            if (n > 20000) begin
                $display("FAIL done_timeout: done counts %0d/%0d/%0d, required %0d/%0d/%0d",
                         blocks_done[0], blocks_done[1], blocks_done[2], b[0] + 1, b[1] + 1, b[2] + 1);
                $fatal(1, "block did not finish");
            end
        end
        start   = 1'b0;
        w_ready = 1'b0;
        @(posedge clk); #1;
        m_valid = 1'b1;
        m_in    = $urandom;
        @(posedge clk); #1 m_valid = 1'b0;
    endtask

    initial begin
        int n = 0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        m_valid = 1'b1;
        m_in    = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 m_valid = 1'b0;
        set_abc(); begin_block(1'b0); finish_block(1'b0);
        set_abc(); begin_block(1'b1); finish_block(1'b1);
        for (int k = 0; k < 16; k++) blk[k] = 32'hFFFF_FFFF;
        is_abc = 1'b0; begin_block(1'b1); finish_block(1'b1);
        for (int k = 0; k < 16; k++) blk[k] = $urandom;
        is_abc = 1'b0; begin_block(1'b1); finish_block(1'b1);
        set_abc(); begin_block(1'b1);
        while (!(sig_run_v[1] && k0_v[1] == 32'd17 && idx[1] == 40)) begin
            w_ready = 1'($urandom % 2);
            @(posedge clk); #1;
            n++;
            if (n > 20000) begin
                $display("FAIL s1_t40_timeout: reached index %0d, required 40", idx[1]);
                $fatal(1, "S1 at t=40 never reached");
            end
        end
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        w_ready = 1'b0;
        @(posedge clk); #1;
        set_abc(); begin_block(1'b1); finish_block(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sha_sched_ctrl.md
Name: sha_sched_ctrl

Overview:
- Controller for the SHA-256 message schedule.
- Accepts a 16-word message block, then emits W[0..63] in order.
- W[0..15] are passed through from the block. W[16..63] are computed with a single shared external sigma datapath (rotate/rotate/shift/XOR unit), time-multiplexed between sigma0 and sigma1 by driving its three shift constants.
- Sits between the message loader and the compression-round unit.

Parameters:
- DATA_W, 32, word width; only 32 is supported.
- SIGMA_LAT, 1, cycles from the sig_run cycle to sig_out being valid; range 0..7, where 0 means combinational.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a block; ignored unless in IDLE
- m_in  in  DATA_W  message word input
- m_valid  in  1  m_in is valid
- m_ready  out  1  controller accepts m_in
- w_out  out  DATA_W  schedule word W[t]
- w_valid  out  1  w_out is valid
- w_ready  in  1  consumer accepts w_out
- w_idx  out  6  index t of w_out
- sig_in  out  DATA_W  operand to the sigma datapath
- sig_k0  out  32  sigma constant 0 (first rotate amount)
- sig_k1  out  32  sigma constant 1 (second rotate amount)
- sig_k2  out  32  sigma constant 2 (shift amount)
- sig_run  out  1  one-cycle issue pulse to the sigma datapath
- sig_out  in  DATA_W  sigma result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after W[63] is accepted

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, t=0, load count=0; all 16 buffer entries are 0.
  - Reset outputs: m_ready=0, w_valid=0, sig_run=0, busy=0, done=0, w_out=0, w_idx=0, sig_in=0, sig_k0/k1/k2=0.
  - Reset mid-block aborts immediately; no done pulse is produced.
- Storage: 16x32 circular buffer; W[t] is held in entry t mod 16.
- IDLE: start=1 -> LOAD, with count=0 and t=0.
- LOAD:
  - m_ready=1.
  - On m_valid&&m_ready, write m_in to buf[count] and increment count.
  - After the 16th accept -> EMIT. m_ready drops in the cycle after the 16th accept.
- EMIT (t<16): w_valid=1, w_out=buf[t], w_idx=t. On w_ready, t++; when t reaches 16 -> S0.
- S0:
  - Drive sig_in=buf[(t-15) mod 16], k0=7, k1=18, k2=3, and pulse sig_run for 1 cycle.
  - Wait SIGMA_LAT cycles, then latch s0=sig_out -> S1.
  - sig_in and the constants are held stable for the whole wait.
- S1:
  - Drive sig_in=buf[(t-2) mod 16], k0=17, k1=19, k2=10, and pulse sig_run.
  - After SIGMA_LAT cycles, latch s1=sig_out -> OUT.
- OUT:
  - Compute buf[t mod 16] <= s1 + buf[(t-7) mod 16] + s0 + buf[t mod 16] (old value, i.e. W[t-16]), modulo 2^32; carries are discarded.
  - Present the new value next cycle with w_valid=1 and w_idx=t.
  - The write happens exactly once per t, independent of w_ready stalls.
- Handshake:
  - w_out, w_idx and w_valid stay stable while w_valid && !w_ready.
  - On acceptance with t<63: t++ -> S0.
  - On acceptance with t=63 -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- busy is high in LOAD, EMIT, S0, S1, OUT and DONE.
- Latency per computed word with w_ready held high: 2*(SIGMA_LAT+1)+2 cycles.
- sig_run is never asserted outside S0/S1, and never twice within one wait window.
- start asserted while busy is ignored. Simultaneous start and rst=0: reset wins.
- m_valid outside LOAD is ignored.

Optional Feature:
- SHA_SCHED_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt (32 bits).
  - Counts cycles with w_valid=1 && w_ready=0.
  - Cleared on reset and on start accepted in IDLE; saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 -> W16=0x61626380, W17=0x000F0000, 64 words with w_idx 0..63, then a single done pulse.
- Same block with w_ready toggling randomly every cycle -> identical 64-word sequence; w_out stable during stalls; stall_cnt (if enabled) equals the number of stalled cycles.
- SIGMA_LAT=0 and SIGMA_LAT=3 with a behavioural sigma model -> same W sequence. Check that sig_k0/k1/k2 alternate between (7,18,3) and (17,19,10), and that sig_run pulses exactly 96 times per block.
- All-ones block (Wi=0xFFFFFFFF) -> sums wrap modulo 2^32 and match the golden model for W16..W63.
- rst=0 asserted while in S1 at t=40 -> all outputs return to their reset values asynchronously, no done pulse; a subsequent start on "abc" produces the correct sequence.
- start pulsed during LOAD and during OUT -> ignored; m_valid pulsed in IDLE -> no buffer write and m_ready stays 0.
